// File: rtl/tft_spi_pkg.sv
// -----------------------------------------------------------------------------
// tft_spi_pkg
// Shared definitions for the TFT SPI receive endpoint: default word width and
// FIFO depth, register-select encodings and the receive FSM state type.
// -----------------------------------------------------------------------------
package tft_spi_pkg;

    // Bits per SPI word, MSB first on the wire.
    localparam int WORD_BITS  = 16;

    // Receive FIFO entries when the FIFO build is selected (power of 2).
    localparam int FIFO_DEPTH = 4;

    // Register-select encodings carried alongside each received word.
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Receive FSM: waiting for chip select, or shifting bits of a word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/tft_spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// tft_spi_rx_fifo
// Small synchronous FIFO holding {rs, word} entries for tft_spi_rx. The head
// entry is presented combinationally on pop_data. The caller only pushes when
// there is room (or a pop happens in the same cycle) and only pops when not
// empty; a simultaneous push and pop while full is therefore legal.
//
// Parameters:
//   Width  entry width in bits
//   Depth  number of entries (power of 2, >= 2)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        discard the head entry
//   pop_data   head entry (undefined while empty)
//   full       Depth entries held
//   empty      no entries held
// -----------------------------------------------------------------------------
module tft_spi_rx_fifo #(
    parameter int Width = 17,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_depth_check
        $error("tft_spi_rx_fifo: Depth must be a power of 2 and at least 2");
    end

    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [AddrW:0]   count;
    logic [Width-1:0] mem [Depth];

    // Pointers wrap naturally because Depth is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AddrW + 1)'(1);
                2'b01:   count <= count - (AddrW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only observed after being
    // written, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (AddrW + 1)'(Depth));
    assign empty    = (count == '0);

endmodule

// File: rtl/tft_spi_rx.sv
// -----------------------------------------------------------------------------
// tft_spi_rx
// Receive-side SPI endpoint for the TFT display link. SPI_CLK, SPI_MOSI,
// SPI_CS and RS are synchronised into the MasterCLK domain, bits are shifted
// in MSB first on SPI_CLK rising edges, and every completed word is offered on
// a valid/ready stream tagged with the RS level (0 = command, 1 = data).
// Several words may be sent back to back under one chip select. Raising CS in
// the middle of a word discards the partial word and pulses frame_abort. A
// completed word that finds the storage full is dropped and sets the sticky
// overflow flag.
//
// Build option:
//   TFT_SPI_RX_FIFO_EN  defined   -> FifoDepth-entry receive FIFO
//                       undefined -> single holding register (FifoDepth unused)
//
// Parameters:
//   WordBits   bits per SPI word
//   FifoDepth  receive FIFO entries (FIFO build only, power of 2)
// Ports:
//   MasterCLK    system clock, all logic on rising edge
//   RST_N        asynchronous active-low reset
//   SPI_CLK      serial clock from the master (asynchronous)
//   SPI_MOSI     serial data, sampled on SPI_CLK rising edge
//   SPI_CS       chip select, active low
//   RS           register select level for the current word
//   rx_word      received word
//   rx_rs        RS captured with rx_word
//   rx_valid     rx_word/rx_rs valid
//   rx_ready     consumer accepts when rx_valid & rx_ready
//   ovf_clr      synchronous clear of overflow
//   overflow     sticky: a completed word was dropped
//   frame_abort  one-cycle pulse: CS rose mid-word
// -----------------------------------------------------------------------------
module tft_spi_rx
    import tft_spi_pkg::*;
#(
    parameter int WordBits  = WORD_BITS,
    parameter int FifoDepth = FIFO_DEPTH
) (
    input  logic                MasterCLK,
    input  logic                RST_N,
    input  logic                SPI_CLK,
    input  logic                SPI_MOSI,
    input  logic                SPI_CS,
    input  logic                RS,
    output logic [WordBits-1:0] rx_word,
    output logic                rx_rs,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic                ovf_clr,
    output logic                overflow,
    output logic                frame_abort
);

    localparam int CntW = (WordBits > 2) ? $clog2(WordBits) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WordBits - 1);

    if (WordBits < 2) begin : g_word_check
        $error("tft_spi_rx: WordBits must be at least 2");
    end

    if (FifoDepth < 1) begin : g_depth_check
        $error("tft_spi_rx: FifoDepth must be positive");
    end

    // -------------------------------------------------------------------------
    // Input synchronisers. Idle levels are used as reset values so a pin that
    // is already at its idle level after reset never looks like an edge.
    // -------------------------------------------------------------------------
    logic [2:0] sclk_q;     // [0],[1] synchroniser, [2] edge-detect history
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic [1:0] rs_q;
    logic       sclk_rise;  // registered, so it lands 3 edges after the pin

    logic cs_sync;
    logic mosi_sync;
    logic rs_sync;

    assign cs_sync   = cs_q[1];
    assign mosi_sync = mosi_q[1];
    assign rs_sync   = rs_q[1];

    // NOTE: every register here uses non-blocking assignment so each flop
    // samples the pre-edge value of its neighbour; blocking assignment would
    // collapse the two-stage synchroniser into a single stage.
    always_ff @(posedge MasterCLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_q    <= 3'b111;
            cs_q      <= 2'b11;
            mosi_q    <= 2'b00;
            rs_q      <= {2{RS_CMD}};
            sclk_rise <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], SPI_CLK};
            cs_q      <= {cs_q[0], SPI_CS};
            mosi_q    <= {mosi_q[0], SPI_MOSI};
            rs_q      <= {rs_q[0], RS};
            sclk_rise <= sclk_q[1] & ~sclk_q[2];
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    rx_state_t           state;
    rx_state_t           state_next;
    logic [CntW-1:0]     bit_cnt;
    logic [WordBits-1:0] shift_reg;
    logic                shift_en;
    logic                cnt_clr;
    logic                push;
    logic                abort_next;
    logic [WordBits:0]   push_data;   // {rs, word}

    // The final bit goes straight into the pushed word, so the word is stored
    // on the same edge that shifts its last bit.
    assign push_data = {rs_sync, shift_reg[WordBits-2:0], mosi_sync};

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        push       = 1'b0;
        abort_next = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!cs_sync) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_sync) begin
                    // CS rising ends the frame; clock edges seen with CS high
                    // are ignored, and a partially shifted word is dropped.
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                    abort_next = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    push     = (bit_cnt == LastBit);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge MasterCLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            frame_abort <= abort_next;
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                // Wrap after the last bit so back-to-back words need no gap.
                bit_cnt <= (bit_cnt == LastBit) ? '0 : bit_cnt + CntW'(1);
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[WordBits-2:0], mosi_sync};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word storage and overflow
    // -------------------------------------------------------------------------
    logic drop;   // a completed word found no room

`ifdef TFT_SPI_RX_FIFO_EN

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              fifo_push;
    logic [WordBits:0] fifo_head;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_pop  = ~fifo_empty & rx_ready;
    assign drop      = push & fifo_full & ~fifo_pop;
    assign fifo_push = push & ~drop;

    tft_spi_rx_fifo #(
        .Width (WordBits + 1),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (MasterCLK),
        .rst_n     (RST_N),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Gate the head so the outputs read zero while nothing is held.
    assign rx_valid         = ~fifo_empty;
    assign {rx_rs, rx_word} = fifo_empty ? '0 : fifo_head;

`else

    logic [WordBits-1:0] hold_word;
    logic                hold_rs;
    logic                hold_valid;

    // The register is free if empty or being consumed this cycle.
    assign drop = push & hold_valid & ~rx_ready;

    always_ff @(posedge MasterCLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_word  <= '0;
            hold_rs    <= 1'b0;
            hold_valid <= 1'b0;
        end else if (push && !drop) begin
            hold_word  <= push_data[WordBits-1:0];
            hold_rs    <= push_data[WordBits];
            hold_valid <= 1'b1;
        end else if (hold_valid && rx_ready) begin
            hold_valid <= 1'b0;
        end
    end

    assign rx_valid = hold_valid;
    assign rx_word  = hold_word;
    assign rx_rs    = hold_rs;

`endif

    // A drop outranks a clear in the same cycle so no lost word goes unseen.
    always_ff @(posedge MasterCLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow <= 1'b0;
        end else begin
            overflow <= drop | (overflow & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_tft_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_tft_spi_rx
// Self-checking bench for tft_spi_rx. SPI frames are driven bit by bit with
// SPI_CLK phases of several MasterCLK periods; a monitor collects every word
// accepted on the output stream, and expectations come from the words the
// bench itself sent (a queue of completed {rs, word} pairs, with partial words
// contributing only an expected abort).
// -----------------------------------------------------------------------------
module tb_tft_spi_rx;
    import tft_spi_pkg::*;

    localparam int W    = WORD_BITS;
    localparam int HALF = 4;   // MasterCLK periods per SPI_CLK phase
`ifdef TFT_SPI_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic         MasterCLK = 1'b0;
    logic         RST_N     = 1'b0;
    logic         SPI_CLK   = 1'b0;
    logic         SPI_MOSI  = 1'b0;
    logic         SPI_CS    = 1'b1;
    logic         RS        = 1'b0;
    logic         rx_ready  = 1'b1;
    logic         ovf_clr   = 1'b0;
    logic [W-1:0] rx_word;
    logic         rx_rs;
    logic         rx_valid;
    logic         overflow;
    logic         frame_abort;

    always #5 MasterCLK = ~MasterCLK;

    tft_spi_rx #(
        .WordBits  (W),
        .FifoDepth (FIFO_DEPTH)
    ) dut (
        .MasterCLK   (MasterCLK),
        .RST_N       (RST_N),
        .SPI_CLK     (SPI_CLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_CS      (SPI_CS),
        .RS          (RS),
        .rx_word     (rx_word),
        .rx_rs       (rx_rs),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .ovf_clr     (ovf_clr),
        .overflow    (overflow),
        .frame_abort (frame_abort)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Output monitor (samples on the falling edge)
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic         rs;
        logic [W-1:0] word;
    } rx_t;

    rx_t  got_q[$];
    rx_t  exp_q[$];
    int   abort_cnt  = 0;
    int   abort_wide = 0;
    int   stable_err = 0;
    logic abort_prev = 1'b0;
    logic stall_prev = 1'b0;
    rx_t  stall_val;

    always @(negedge MasterCLK) begin
        if (frame_abort) abort_cnt++;
        if (frame_abort && abort_prev) abort_wide++;
        abort_prev = frame_abort;
        if (stall_prev && rx_valid && ({rx_rs, rx_word} !== stall_val)) stable_err++;
        stall_prev = rx_valid && !rx_ready;
        stall_val  = {rx_rs, rx_word};
        if (rx_valid && rx_ready) got_q.push_back({rx_rs, rx_word});
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after a rising edge
    // ------------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge MasterCLK);
            #2;
        end
    endtask

    task automatic spi_bit(input logic b);
        SPI_MOSI = b;
        SPI_CLK  = 1'b0;
        cyc(HALF);
        SPI_CLK  = 1'b1;
        cyc(HALF);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) spi_bit(w[i]);
    endtask

    task automatic frame_begin(input logic rs);
        RS     = rs;
        SPI_CS = 1'b0;
        cyc(2);
    endtask

    task automatic frame_end();
        SPI_CLK = 1'b0;
        cyc(HALF);
        SPI_CS = 1'b1;
        cyc(6);
    endtask

    // Waits (bounded) until n words have been collected, then checks the count.
    task automatic wait_got(input string name, input int n);
        int budget;
        budget = 200;
        while (got_q.size() < n && budget > 0) begin
            cyc(1);
            budget--;
        end
        cyc(2);
        check(name, 32'(got_q.size()), 32'(n));
    endtask

    // Compares collected words with the expected queue, entry by entry.
    task automatic compare_queues(input string name);
        wait_got(name, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(name, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    // ------------------------------------------------------------------------
    // Table of single-word frames, optionally followed by a partial word
    // ------------------------------------------------------------------------
    typedef struct {
        logic         rs;
        logic [W-1:0] word;
        int           tail_bits;   // extra bits before CS rises (0 = clean end)
        int           exp_words;
        int           exp_aborts;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        lat;
        int        abort_base;
        logic [W-1:0] w;
        logic [W-1:0] ov_words[CAP + 1];

        vecs[0] = '{RS_CMD,  16'hFFFF, 0,  1, 0};
        vecs[1] = '{RS_DATA, 16'h0000, 0,  1, 0};
        vecs[2] = '{RS_DATA, 16'h8001, 5,  1, 1};
        vecs[3] = '{RS_CMD,  16'h5555, 15, 1, 1};
        vecs[4] = '{RS_CMD,  16'hAAAA, 1,  1, 1};
        vecs[5] = '{RS_DATA, 16'h7FFE, 0,  1, 0};

        // ---- Reset held with toggling pins --------------------------------
        @(posedge MasterCLK);
        #2;
        for (int i = 0; i < 5; i++) begin
            SPI_CLK  = ~SPI_CLK;
            SPI_CS   = ~SPI_CS;
            SPI_MOSI = ~SPI_MOSI;
            RS       = ~RS;
            cyc(1);
            check("reset_outputs", 32'({rx_valid, overflow, frame_abort, rx_rs, rx_word}), 32'd0);
        end
        SPI_CLK = 1'b0;
        SPI_CS  = 1'b1;
        RS      = 1'b0;
        cyc(2);
        RST_N = 1'b1;
        cyc(4);
        check("reset_no_abort", 32'(abort_cnt), 32'd0);
        check("reset_idle_valid", 32'(rx_valid), 32'd0);

        // ---- Single command with latency measurement ----------------------
        got_q.delete();
        rx_ready = 1'b1;
        frame_begin(RS_CMD);
        w = 16'hA5C3;
        for (int i = W - 1; i >= 1; i--) spi_bit(w[i]);
        SPI_MOSI = w[0];
        SPI_CLK  = 1'b0;
        cyc(HALF);
        SPI_CLK = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge MasterCLK);
            #1;
            if (rx_valid) begin
                lat = k;
                break;
            end
        end
        #1;
        cyc(HALF);
        frame_end();
        check("single_latency", 32'(lat), 32'd4);
        check("single_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("single_word", 32'(got_q[0]), 32'({RS_CMD, 16'hA5C3}));
        check("single_valid_drop", 32'(rx_valid), 32'd0);

        // ---- Back-to-back data words under one CS -------------------------
        got_q.delete();
        exp_q.delete();
        abort_base = abort_cnt;
        frame_begin(RS_DATA);
        send_word(16'h2A00);
        send_word(16'h00EF);
        frame_end();
        exp_q.push_back({RS_DATA, 16'h2A00});
        exp_q.push_back({RS_DATA, 16'h00EF});
        compare_queues("b2b");
        check("b2b_no_abort", 32'(abort_cnt - abort_base), 32'd0);

        // ---- Abort after 7 bits, then a clean frame -----------------------
        got_q.delete();
        abort_base = abort_cnt;
        frame_begin(RS_CMD);
        for (int i = 0; i < 7; i++) spi_bit(1'(i & 1));
        frame_end();
        check("abort_pulse", 32'(abort_cnt - abort_base), 32'd1);
        check("abort_no_word", 32'(got_q.size()), 32'd0);
        frame_begin(RS_DATA);
        send_word(16'h1234);
        frame_end();
        wait_got("after_abort_count", 1);
        if (got_q.size() > 0) check("after_abort_word", 32'(got_q[0]), 32'({RS_DATA, 16'h1234}));

        // ---- Table-driven frames ------------------------------------------
        for (int v = 0; v < 6; v++) begin
            got_q.delete();
            abort_base = abort_cnt;
            frame_begin(vecs[v].rs);
            send_word(vecs[v].word);
            for (int b = 0; b < vecs[v].tail_bits; b++) spi_bit(1'b1);
            frame_end();
            wait_got("vec_count", vecs[v].exp_words);
            if (got_q.size() > 0) check("vec_word", 32'(got_q[0]), 32'({vecs[v].rs, vecs[v].word}));
            check("vec_aborts", 32'(abort_cnt - abort_base), 32'(vecs[v].exp_aborts));
        end

        // ---- Randomised frames against the queue model --------------------
        got_q.delete();
        exp_q.delete();
        abort_base = abort_cnt;
        lat = 0;  // reused as expected abort count
        for (int f = 0; f < 25; f++) begin
            logic rs;
            int   nw;
            int   pb;
            rs = 1'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 3));
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0;
            frame_begin(rs);
            for (int j = 0; j < nw; j++) begin
                w = W'($urandom);
                send_word(w);
                exp_q.push_back({rs, w});
            end
            for (int b = 0; b < pb; b++) spi_bit(1'($urandom_range(0, 1)));
            if (pb != 0) lat++;
            frame_end();
        end
        compare_queues("random");
        check("random_aborts", 32'(abort_cnt - abort_base), 32'(lat));

        // ---- Overflow under back-pressure ---------------------------------
        got_q.delete();
        rx_ready = 1'b0;
        cyc(1);
        frame_begin(RS_DATA);
        for (int i = 0; i <= CAP; i++) begin
            ov_words[i] = W'(16'hC000 + i * 16'h0111);
            send_word(ov_words[i]);
        end
        frame_end();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_held_valid", 32'(rx_valid), 32'd1);
        check("ovf_head", 32'({rx_rs, rx_word}), 32'({RS_DATA, ov_words[0]}));
        rx_ready = 1'b1;
        cyc(CAP + 4);
        check("ovf_drain_count", 32'(got_q.size()), 32'(CAP));
        for (int i = 0; i < CAP && i < got_q.size(); i++) begin
            check("ovf_drain_word", 32'(got_q[i]), 32'({RS_DATA, ov_words[i]}));
        end
        check("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        cyc(1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // ---- Reset in the middle of a word --------------------------------
        got_q.delete();
        frame_begin(RS_CMD);
        for (int i = 0; i < 9; i++) spi_bit(1'b1);
        abort_base = abort_cnt;
        RST_N = 1'b0;
        cyc(3);
        check("midreset_outputs", 32'({rx_valid, overflow, frame_abort, rx_rs, rx_word}), 32'd0);
        RST_N = 1'b1;
        cyc(3);
        SPI_CS = 1'b1;
        cyc(6);
        frame_begin(RS_CMD);
        send_word(16'h0F0F);
        frame_end();
        wait_got("midreset_count", 1);
        if (got_q.size() > 0) check("midreset_word", 32'(got_q[0]), 32'({RS_CMD, 16'h0F0F}));
        check("midreset_no_abort", 32'(abort_cnt - abort_base), 32'd0);

        // ---- Whole-run properties -----------------------------------------
        check("abort_single_cycle", 32'(abort_wide), 32'd0);
        check("stall_stable", 32'(stable_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
